// File: rtl/multi_port_ram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multi_port_ram_arb                                            |
// | Purpose  : N-port synchronous RAM with valid/ready requests, registered  |
// |            read return and rotating-priority same-address arbitration.   |
// | Options  : define MULTI_PORT_RAM_INIT_EN to zero-fill memory after reset |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module multi_port_ram_arb #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            valid,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data,
  output logic [NUM_PORTS-1:0]            ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] q,
  output logic [NUM_PORTS-1:0]            q_valid
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(NUM_PORTS - 1);

  logic [DATA_WIDTH-1:0]           mem [DEPTH];
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] q_q, q_d;
  logic [NUM_PORTS-1:0]            q_valid_q, q_valid_d;
  logic [NUM_PORTS-1:0]            w_lost;
  logic [NUM_PORTS-1:0]            w_fire;
  logic                            w_run;

  // Rank of port p relative to the rotating pointer; 0 is the highest priority.
  function automatic int prio(input int p, input logic [PTR_W-1:0] ptr);
    return (p - int'(ptr) + NUM_PORTS) % NUM_PORTS;
  endfunction

`ifdef MULTI_PORT_RAM_INIT_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  w_clr_we;

  // Sweep one address per cycle, then hand the array over to the ports.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) state_d = ST_RUN;
    end
  end

  // Clear FSM state; reset restarts the sweep from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // rst_n keeps the sweep from writing while reset is held.
  assign w_clr_we = (state_q == ST_CLEAR) && rst_n;
  assign w_run    = (state_q == ST_RUN);
`else
  // Ports are serviced whenever reset is released; gating by rst_n keeps
  // requests from landing on an edge that occurs while reset is held.
  assign w_run = rst_n;
`endif

  // A port loses when a valid conflicting port outranks it; idle ports stay ready.
  always_comb begin
    w_lost = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if ((i != j) && valid[i] && valid[j] &&
            (addr[i*ADDR_WIDTH +: ADDR_WIDTH] == addr[j*ADDR_WIDTH +: ADDR_WIDTH]) &&
            (we[i] || we[j]) && (prio(j, rr_ptr_q) < prio(i, rr_ptr_q))) begin
          w_lost[i] = 1'b1;
        end
      end
    end
    ready  = w_run ? ~w_lost : '0;
    w_fire = valid & ready;
  end

  // Next read data/strobes and pointer rotation on any conflict stall.
  always_comb begin
    q_d       = q_q;
    q_valid_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_fire[i] && !we[i]) begin
        q_d[i*DATA_WIDTH +: DATA_WIDTH] = mem[addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        q_valid_d[i]                    = 1'b1;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (w_run && |(valid & w_lost)) begin
      rr_ptr_d = (rr_ptr_q == C_PTR_LAST) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  // Read return, strobes and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      q_valid_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Storage array; accepted writes never share an address in one cycle.
  always_ff @(posedge clk) begin
`ifdef MULTI_PORT_RAM_INIT_EN
    if (w_clr_we) mem[clr_addr_q] <= '0;
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_fire[i] && we[i]) begin
        mem[addr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_port_ram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multi_port_ram_arb                                         |
// | Purpose  : Directed self-checking bench for multi_port_ram_arb (2 ports) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_multi_port_ram_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  valid;
  logic [1:0]  we;
  logic [11:0] addr;
  logic [15:0] data;
  logic [1:0]  ready;
  logic [15:0] q;
  logic [1:0]  q_valid;

  int n_checks = 0;
  int n_fail   = 0;

  multi_port_ram_arb #(
    .NUM_PORTS (2),
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (valid),
    .we     (we),
    .addr   (addr),
    .data   (data),
    .ready  (ready),
    .q      (q),
    .q_valid(q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    we    = '0;
    addr  = '0;
    data  = '0;

    // Reset state
    #2;
    check("rst_q", 32'(q), 32'h0);
    check("rst_q_valid", 32'(q_valid), 32'h0);
    check("rst_rr", 32'(dut.rr_ptr_q), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(ready), 32'h3);

    // Write then read back on the other port
    valid = 2'b01; we = 2'b01; addr = {6'h00, 6'h10}; data = {8'h00, 8'hA5};
    #1;
    check("wr_ready", 32'(ready), 32'h3);
    tick();
    valid = 2'b10; we = 2'b00; addr = {6'h10, 6'h00};
    #1;
    check("rd_ready1", 32'(ready[1]), 32'h1);
    tick();
    valid = 2'b00;
    check("rd_qv", 32'(q_valid), 32'h2);
    check("rd_q1", 32'(q[15:8]), 32'hA5);
    tick();
    check("rd_qv_pulse", 32'(q_valid), 32'h0);
    check("rd_q1_hold", 32'(q[15:8]), 32'hA5);

    // Write/read conflict, port 0 wins with rr_ptr=0
    valid = 2'b11; we = 2'b01; addr = {6'h05, 6'h05}; data = {8'h00, 8'h3C};
    #1;
    check("cf_ready", 32'(ready), 32'h1);
    check("cf_rr0", 32'(dut.rr_ptr_q), 32'h0);
    tick();
    check("cf_rr1", 32'(dut.rr_ptr_q), 32'h1);
    valid = 2'b10;
    #1;
    check("cf_ready_retry", 32'(ready), 32'h3);
    tick();
    valid = 2'b00;
    check("cf_qv", 32'(q_valid), 32'h2);
    check("cf_q1", 32'(q[15:8]), 32'h3C);
    check("cf_rr_hold", 32'(dut.rr_ptr_q), 32'h1);

    // Write/write conflict for 4 cycles from rr_ptr=1: grants 1,0,1,0
    valid = 2'b11; we = 2'b11; addr = {6'h07, 6'h07}; data = {8'h22, 8'h11};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("ww_ready", 32'(ready), (k % 2 == 0) ? 32'h2 : 32'h1);
      tick();
      check("ww_rr", 32'(dut.rr_ptr_q), (k % 2 == 0) ? 32'h0 : 32'h1);
    end
    valid = 2'b01; we = 2'b00; addr = {6'h00, 6'h07};
    tick();
    valid = 2'b00;
    check("ww_qv", 32'(q_valid), 32'h1);
    check("ww_final", 32'(q[7:0]), 32'h11);

    // Different-address writes proceed together
    valid = 2'b11; we = 2'b11; addr = {6'h21, 6'h20}; data = {8'h5A, 8'h99};
    #1;
    check("da_ready", 32'(ready), 32'h3);
    tick();
    check("da_rr", 32'(dut.rr_ptr_q), 32'h1);

    // Shared-address reads with no writer are all accepted
    valid = 2'b11; we = 2'b00; addr = {6'h20, 6'h20};
    #1;
    check("rr_ready", 32'(ready), 32'h3);
    tick();
    check("rr_qv", 32'(q_valid), 32'h3);
    check("rr_q", 32'(q), 32'h9999);
    check("rr_rr", 32'(dut.rr_ptr_q), 32'h1);
    valid = 2'b10; addr = {6'h21, 6'h20};
    tick();
    valid = 2'b00;
    check("da_q1", 32'(q[15:8]), 32'h5A);
    check("da_q0_hold", 32'(q[7:0]), 32'h99);
    check("da_qv", 32'(q_valid), 32'h2);

    // Reset right after an accepted read; a write held during reset is dropped
    rst_n = 1'b0;
    #1;
    check("ar_qv", 32'(q_valid), 32'h0);
    check("ar_q", 32'(q), 32'h0);
    check("ar_rr", 32'(dut.rr_ptr_q), 32'h0);
    valid = 2'b01; we = 2'b01; addr = {6'h00, 6'h20}; data = {8'h00, 8'hEE};
    tick();
    valid = 2'b00; we = 2'b00;
    rst_n = 1'b1;
    #1;
    check("ar_ready", 32'(ready), 32'h3);
    valid = 2'b01; addr = {6'h00, 6'h20};
    tick();
    valid = 2'b00;
    check("ar_nowrite", 32'(q[7:0]), 32'h99);

    // Pointer back at 0 after reset: port 0 wins again
    valid = 2'b11; we = 2'b10; addr = {6'h05, 6'h05}; data = {8'h44, 8'h00};
    #1;
    check("ar_cf_ready", 32'(ready), 32'h1);
    tick();
    valid = 2'b00;
    check("ar_cf_q0", 32'(q[7:0]), 32'h3C);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
